vscale_hasti_sram_slave: RTL and testbench

//  HASTI (AHB-lite) responder backed by a word-organised on-chip RAM; the target end of the

---
 rtl/vscale_hasti_sram_slave.sv | 263 ++++++++++++++++++++++++++
 tb/tb_vscale_hasti_sram_slave.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_hasti_sram_slave.sv
// ----------------------------------------------------------------------------
// vscale_hasti_sram_slave
//
// HASTI (AHB-lite) responder backed by a word-organised on-chip RAM. It is the
// target end of the imem/dmem master ports of the core's HASTI bridges and is
// used as boot/test memory.
//
// Each accepted transfer (hready & hsel & htrans[1]) has its address-phase
// controls captured. The data phase then optionally spends WAIT_STATES
// cycles with hready low before a single DATA cycle. In that DATA cycle a
// read returns the full 32-bit word, and a write commits the byte lanes
// selected by size and address at the closing edge.
//
// Optional feature macro: VSCALE_HASTI_SRAM_ERR_EN
//   When defined, the following accesses get a two-cycle ERROR response
//   (ERR1: hready=0/hresp=1, ERR2: hready=1/hresp=1) and are not
//   performed:
//     - addresses outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS)
//     - hsize > 2
//     - misaligned half or word accesses
//   When undefined, hresp is tied to OKAY. Out-of-range addresses alias
//   modulo the byte span, and misaligned accesses simply use the lane masks.
//
// Parameters
//   DEPTH_WORDS  RAM depth in 32-bit words (power of two)
//   BASE_ADDR    byte address of word 0, aligned to 4*DEPTH_WORDS
//   WAIT_STATES  data-phase wait cycles per accepted transfer, 0..7
//
// Ports
//   clk        clock; all state changes on the rising edge
//   reset_n    asynchronous assert / synchronous deassert, active low
//   hsel       slave select
//   haddr      byte address (address phase)
//   hwrite     1 = write, 0 = read (address phase)
//   hsize      0 = byte, 1 = half, 2 = word (address phase)
//   hburst     unused; every beat is decoded on its own
//   hmastlock  unused
//   hprot      unused
//   htrans     0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ
//   hwdata     write data (data phase)
//   hrdata     read data; nonzero only in the DATA cycle of a read
//   hready     transfer complete / slave ready
//   hresp      0 = OKAY, 1 = ERROR
// ----------------------------------------------------------------------------

`ifndef HASTI_ADDR_WIDTH
`define HASTI_ADDR_WIDTH 32
`endif
`ifndef HASTI_BUS_WIDTH
`define HASTI_BUS_WIDTH 32
`endif
`ifndef HASTI_SIZE_WIDTH
`define HASTI_SIZE_WIDTH 3
`endif
`ifndef HASTI_BURST_WIDTH
`define HASTI_BURST_WIDTH 3
`endif
`ifndef HASTI_PROT_WIDTH
`define HASTI_PROT_WIDTH 4
`endif
`ifndef HASTI_TRANS_WIDTH
`define HASTI_TRANS_WIDTH 2
`endif
`ifndef HASTI_RESP_WIDTH
`define HASTI_RESP_WIDTH 1
`endif

module vscale_hasti_sram_slave #(
   parameter int unsigned                      DEPTH_WORDS = 16384,
   parameter logic [`HASTI_ADDR_WIDTH-1:0]     BASE_ADDR   = '0,
   parameter int unsigned                      WAIT_STATES = 0
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                hsel,
   input  logic [`HASTI_ADDR_WIDTH-1:0]        haddr,
   input  logic                                hwrite,
   input  logic [`HASTI_SIZE_WIDTH-1:0]        hsize,
   input  logic [`HASTI_BURST_WIDTH-1:0]       hburst,
   input  logic                                hmastlock,
   input  logic [`HASTI_PROT_WIDTH-1:0]        hprot,
   input  logic [`HASTI_TRANS_WIDTH-1:0]       htrans,
   input  logic [`HASTI_BUS_WIDTH-1:0]         hwdata,
   output logic [`HASTI_BUS_WIDTH-1:0]         hrdata,
   output logic                                hready,
   output logic [`HASTI_RESP_WIDTH-1:0]        hresp
);

   localparam int AW    = `HASTI_ADDR_WIDTH;
   localparam int SW    = `HASTI_SIZE_WIDTH;
   localparam int IDX_W = $clog2(DEPTH_WORDS);

   // Last value of the wait counter before moving to DATA.
   localparam logic [2:0] WAIT_LAST = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t            state_reg, state_next;
   logic [2:0]        cnt_reg, cnt_next;
   logic [AW-1:0]     addr_reg;
   logic              write_reg;
   logic [SW-1:0]     size_reg;

   logic              accept;
   logic              access_bad;
   logic [AW-1:0]     rd_addr;
   logic [IDX_W-1:0]  rd_idx;
   logic [IDX_W-1:0]  wr_idx;
   logic [3:0]        wmask;
   logic              we;
   logic [31:0]       rd_word;

   // Word index relative to BASE_ADDR; bits above the RAM span are dropped,
   // which gives the aliasing behaviour when range checking is disabled.
   function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] a);
      return IDX_W'((a - BASE_ADDR) >> 2);
   endfunction

   assign accept = hready && hsel && htrans[1];

   // ------------------------------------------------------------------------
   // Error classification of the transfer in its address phase
   // ------------------------------------------------------------------------
`ifdef VSCALE_HASTI_SRAM_ERR_EN
   logic [AW-1:0] req_off;
   logic          out_of_range;
   logic          bad_size;
   logic          misaligned;

   // An address below BASE_ADDR wraps to a huge offset, so a single unsigned
   // test covers both ends of the window.
   assign req_off      = haddr - BASE_ADDR;
   assign out_of_range = (req_off >> (IDX_W + 2)) != '0;
   assign bad_size     = hsize > SW'(2);
   assign misaligned   = ((hsize == SW'(1)) && haddr[0]) ||
                         ((hsize == SW'(2)) && (haddr[1:0] != 2'b00));
   assign access_bad   = out_of_range || bad_size || misaligned;
`else
   assign access_bad   = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         addr_reg  <= '0;
         write_reg <= 1'b0;
         size_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            addr_reg  <= haddr;
            write_reg <= hwrite;
            size_reg  <= hsize;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         // All ready states decode the next address phase the same way;
         // ERR2 included, since hready is already high there.
         S_IDLE, S_DATA, S_ERR2: begin
            if (accept) begin
               if (access_bad) begin
                  state_next = S_ERR1;
               end else if (WAIT_STATES != 0) begin
                  state_next = S_WAIT;
                  cnt_next   = '0;
               end else begin
                  state_next = S_DATA;
               end
            end else begin
               state_next = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_reg == WAIT_LAST) begin
               state_next = S_DATA;
            end else begin
               cnt_next = cnt_reg + 3'd1;
            end
         end
         S_ERR1: begin
            state_next = S_ERR2;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign hready = (state_reg != S_WAIT) && (state_reg != S_ERR1);

`ifdef VSCALE_HASTI_SRAM_ERR_EN
   assign hresp = ((state_reg == S_ERR1) || (state_reg == S_ERR2)) ? `HASTI_RESP_WIDTH'(1) : '0;
`else
   assign hresp = '0;
`endif

   // ------------------------------------------------------------------------
   // RAM: four byte-wide lanes, registered read
   // ------------------------------------------------------------------------
   // The read port follows the address that will sit in addr_reg next cycle.
   // It is therefore already loaded with the right word when DATA starts,
   // whether DATA follows the accept directly or a run of wait cycles.
   assign rd_addr = accept ? haddr : addr_reg;
   assign rd_idx  = word_idx(rd_addr);
   assign wr_idx  = word_idx(addr_reg);
   assign we      = (state_reg == S_DATA) && write_reg;

   always_comb begin
      wmask = 4'b1111;
      case (size_reg)
         SW'(0):  wmask = 4'b0001 << addr_reg[1:0];
         SW'(1):  wmask = 4'b0011 << {addr_reg[1], 1'b0};
         default: wmask = 4'b1111;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH_WORDS];
         logic [7:0] rd_reg;

         // A read accepted in the data phase of a write to the same word
         // must see the new bytes, so the lane is written through to the
         // read register when both hit the same index on the same edge.
         always_ff @(posedge clk) begin
            if (we && wmask[gi]) begin
               mem[wr_idx] <= hwdata[8*gi +: 8];
            end
            if (we && wmask[gi] && (wr_idx == rd_idx)) begin
               rd_reg <= hwdata[8*gi +: 8];
            end else begin
               rd_reg <= mem[rd_idx];
            end
         end

         assign rd_word[8*gi +: 8] = rd_reg;
      end
   endgenerate

   assign hrdata = ((state_reg == S_DATA) && !write_reg) ? rd_word : '0;

   // Bus controls this slave deliberately ignores.
   logic unused_ok;
   assign unused_ok = ^{hburst, hmastlock, hprot};

endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// ----------------------------------------------------------------------------
// tb_vscale_hasti_sram_slave
//
// Two instances share the clock and reset:
//   u_ws0 - WAIT_STATES = 0, BASE_ADDR = 0
//   u_ws3 - WAIT_STATES = 3, BASE_ADDR = 0x0001_0000
//
// A pipelined master task plays transfer lists. The expected response is
// built from a byte-lane memory model and queued when the address phase is
// accepted. A per-instance monitor pops the queue when the data phase
// completes, and checks hresp, the number of wait cycles and, for reads,
// hrdata.
// ----------------------------------------------------------------------------
module tb_vscale_hasti_sram_slave;

   localparam int          DEPTH = 256;
   localparam logic [31:0] BASE0 = 32'h0000_0000;
   localparam logic [31:0] BASE1 = 32'h0001_0000;
   localparam int          LIMIT = 40;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic        hsel   [2];
   logic [31:0] haddr  [2];
   logic        hwrite [2];
   logic [2:0]  hsize  [2];
   logic [1:0]  htrans [2];
   logic [31:0] hwdata [2];
   logic [31:0] hrdata [2];
   logic        hready [2];
   logic        hresp  [2];

   vscale_hasti_sram_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE0), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .reset_n(reset_n), .hsel(hsel[0]), .haddr(haddr[0]), .hwrite(hwrite[0]),
      .hsize(hsize[0]), .hburst(3'd0), .hmastlock(1'b0), .hprot(4'd0), .htrans(htrans[0]),
      .hwdata(hwdata[0]), .hrdata(hrdata[0]), .hready(hready[0]), .hresp(hresp[0]));

   vscale_hasti_sram_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE1), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .reset_n(reset_n), .hsel(hsel[1]), .haddr(haddr[1]), .hwrite(hwrite[1]),
      .hsize(hsize[1]), .hburst(3'd0), .hmastlock(1'b0), .hprot(4'd0), .htrans(htrans[1]),
      .hwdata(hwdata[1]), .hrdata(hrdata[1]), .hready(hready[1]), .hresp(hresp[1]));

   typedef struct {
      logic        wr;
      logic [2:0]  size;
      logic [1:0]  trans;
      logic [31:0] addr;
      logic [31:0] wdata;
   } tr_t;

   typedef struct {
      logic        rd;
      logic        resp;
      logic [31:0] waits;
      logic [31:0] data;
      logic [31:0] addr;
   } exp_t;

   tr_t         seq_q [$];
   exp_t        sb0 [$];
   exp_t        sb1 [$];
   logic [31:0] mdl [int];

   int total_cnt = 0;
   int bad_cnt   = 0;

   logic        dp_valid  [2];
   logic [31:0] waits     [2];
   logic [31:0] dp_cycles [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   function automatic logic [31:0] base_of(input int u);
      return (u == 0) ? BASE0 : BASE1;
   endfunction

   function automatic logic [31:0] ws_of(input int u);
      return (u == 0) ? 32'd0 : 32'd3;
   endfunction

   task automatic add(input logic wr, input logic [2:0] size, input logic [1:0] trans,
                      input logic [31:0] addr, input logic [31:0] wdata);
      tr_t t;
      t.wr = wr; t.size = size; t.trans = trans; t.addr = addr; t.wdata = wdata;
      seq_q.push_back(t);
   endtask

   // Builds the expected response for an accepted transfer and, for a good
   // write, applies it to the model.
   task automatic sb_push(input int u, input tr_t t);
      exp_t        e;
      logic [31:0] off;
      logic [31:0] word;
      logic [3:0]  m;
      logic        bad;
      int          key;
      off = t.addr - base_of(u);
      key = u * 65536 + int'((off >> 2) & (DEPTH - 1));
      bad = 1'b0;
`ifdef VSCALE_HASTI_SRAM_ERR_EN
      bad = (off >= 4 * DEPTH) || (t.size > 3'd2) ||
            ((t.size == 3'd1) && t.addr[0]) ||
            ((t.size == 3'd2) && (t.addr[1:0] != 2'b00));
`endif
      e.rd    = !t.wr;
      e.resp  = bad;
      e.waits = bad ? 32'd1 : ws_of(u);
      e.addr  = t.addr;
      e.data  = 32'h0;
      if (!bad) begin
         if (t.wr) begin
            word = mdl.exists(key) ? mdl[key] : 32'h0;
            case (t.size)
               3'd0:    m = 4'b0001 << t.addr[1:0];
               3'd1:    m = 4'b0011 << {t.addr[1], 1'b0};
               default: m = 4'b1111;
            endcase
            for (int b = 0; b < 4; b++) begin
               if (m[b]) word[8*b +: 8] = t.wdata[8*b +: 8];
            end
            mdl[key] = word;
         end else begin
            e.data = mdl.exists(key) ? mdl[key] : 32'hxxxx_xxxx;
         end
      end
      if (u == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endtask

   task automatic wait_ready(input int u);
      int n;
      n = 0;
      @(negedge clk);
      while (!hready[u] && n < LIMIT) begin
         n++;
         @(negedge clk);
      end
      if (!hready[u]) chk($sformatf("u%0d_hready_timeout", u), 32'(hready[u]), 32'd1);
      @(posedge clk);
      #1;
   endtask

   // Plays seq_q as a pipelined master: the next address phase overlaps the
   // current data phase, and hwdata follows its write one phase later.
   task automatic run_seq(input int u);
      tr_t cur;
      tr_t prev;
      bit  have_cur;
      bit  have_prev;
      have_prev = 1'b0;
      cur = '{default: '0};
      prev = cur;
      while (seq_q.size() != 0 || have_prev) begin
         have_cur = (seq_q.size() != 0);
         if (have_cur) begin
            cur       = seq_q.pop_front();
            hsel[u]   = 1'b1;
            haddr[u]  = cur.addr;
            hwrite[u] = cur.wr;
            hsize[u]  = cur.size;
            htrans[u] = cur.trans;
         end else begin
            htrans[u] = 2'd0;
         end
         hwdata[u] = (have_prev && prev.wr) ? prev.wdata : 32'h0;
         wait_ready(u);
         if (have_cur) sb_push(u, cur);
         prev      = cur;
         have_prev = have_cur;
      end
      htrans[u] = 2'd0;
      hwdata[u] = 32'h0;
   endtask

   task automatic mon_step(input int u);
      exp_t e;
      int   n;
      n = (u == 0) ? sb0.size() : sb1.size();
      if (!reset_n) begin
         dp_valid[u] = 1'b0;
         waits[u]    = 0;
         if (u == 0) sb0.delete();
         else        sb1.delete();
         return;
      end
      if (dp_valid[u]) begin
         dp_cycles[u]++;
         if (!hready[u]) begin
            waits[u]++;
            if (n > 0) begin
               e = (u == 0) ? sb0[0] : sb1[0];
               chk($sformatf("u%0d_wait_hresp@%h", u, e.addr), 32'(hresp[u]), 32'(e.resp));
            end
         end else begin
            if (n == 0) begin
               chk($sformatf("u%0d_sb_underflow", u), 32'(n), 32'd1);
            end else begin
               e = (u == 0) ? sb0.pop_front() : sb1.pop_front();
               chk($sformatf("u%0d_hresp@%h", u, e.addr), 32'(hresp[u]), 32'(e.resp));
               chk($sformatf("u%0d_waits@%h", u, e.addr), waits[u], e.waits);
               if (e.rd) chk($sformatf("u%0d_rdata@%h", u, e.addr), hrdata[u], e.data);
            end
            waits[u] = 0;
         end
      end
      if (hready[u]) dp_valid[u] = hsel[u] && htrans[u][1];
   endtask

   always @(negedge clk) begin
      mon_step(0);
      mon_step(1);
   end

   initial begin
      for (int u = 0; u < 2; u++) begin
         hsel[u] = 1'b0; haddr[u] = '0; hwrite[u] = 1'b0; hsize[u] = 3'd2;
         htrans[u] = 2'd0; hwdata[u] = '0;
         dp_valid[u] = 1'b0; waits[u] = 0; dp_cycles[u] = 0;
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("u%0d_rst_hready", u), 32'(hready[u]), 32'd1);
         chk($sformatf("u%0d_rst_hresp", u), 32'(hresp[u]), 32'd0);
         chk($sformatf("u%0d_rst_hrdata", u), hrdata[u], 32'd0);
      end
      @(posedge clk); #2; reset_n = 1'b1;
      @(posedge clk); #1;

      // Word write then pipelined read, zero wait
      dp_cycles[0] = 0;
      add(1, 3'd2, 2'd2, 32'h10, 32'hDEADBEEF);
      add(0, 3'd2, 2'd2, 32'h10, 32'h0);
      run_seq(0);
      chk("u0_wr_rd_dp_cycles", dp_cycles[0], 32'd2);

      // Byte and half writes, each read back in the write's data phase
      add(1, 3'd2, 2'd2, 32'h10, 32'h11223344);
      add(1, 3'd0, 2'd2, 32'h13, 32'hAA000000);
      add(0, 3'd2, 2'd2, 32'h10, 32'h0);
      add(1, 3'd1, 2'd2, 32'h12, 32'h55660000);
      add(0, 3'd2, 2'd2, 32'h10, 32'h0);
      run_seq(0);

      // Wait states: single transfers, then a 4-beat read burst
      add(1, 3'd2, 2'd2, BASE1 + 32'h10, 32'h0BADF00D);
      add(0, 3'd2, 2'd2, BASE1 + 32'h10, 32'h0);
      for (int i = 0; i < 4; i++) add(1, 3'd2, 2'd2, BASE1 + 32'h20 + 32'(4*i), 32'hC0DE0000 + 32'(i));
      run_seq(1);
      dp_cycles[1] = 0;
      add(0, 3'd2, 2'd2, BASE1 + 32'h20, 32'h0);
      for (int i = 1; i < 4; i++) add(0, 3'd2, 2'd3, BASE1 + 32'h20 + 32'(4*i), 32'h0);
      run_seq(1);
      chk("u1_burst4_dp_cycles", dp_cycles[1], 32'd16);

`ifdef VSCALE_HASTI_SRAM_ERR_EN
      // Range and alignment errors; RAM must be left untouched
      add(1, 3'd2, 2'd2, 32'h0, 32'h01020304);
      add(0, 3'd2, 2'd2, 32'(4*DEPTH), 32'h0);
      add(1, 3'd2, 2'd2, 32'h2, 32'hFFFFFFFF);
      add(0, 3'd2, 2'd2, 32'h0, 32'h0);
      add(1, 3'd1, 2'd2, 32'h5, 32'hFFFFFFFF);
      add(0, 3'd2, 2'd2, 32'h4, 32'h0);
      run_seq(0);
      add(0, 3'd2, 2'd2, BASE1 - 32'h4, 32'h0);
      add(0, 3'd2, 2'd2, BASE1 + 32'h10, 32'h0);
      run_seq(1);
`else
      // Aliasing above the span and misaligned half write
      add(1, 3'd2, 2'd2, 32'h0, 32'h01020304);
      add(1, 3'd2, 2'd2, 32'(4*DEPTH) + 32'h4, 32'hCAFEF00D);
      add(0, 3'd2, 2'd2, 32'h4, 32'h0);
      add(1, 3'd1, 2'd2, 32'h1, 32'h0000BEEF);
      add(0, 3'd2, 2'd2, 32'h0, 32'h0);
      add(0, 3'd2, 2'd2, 32'(4*DEPTH), 32'h0);
      run_seq(0);
`endif

      // Reset during the wait states of a write aborts it
      add(1, 3'd2, 2'd2, BASE1 + 32'h40, 32'h11111111);
      run_seq(1);
      hsel[1] = 1'b1; haddr[1] = BASE1 + 32'h40; hwrite[1] = 1'b1;
      hsize[1] = 3'd2; htrans[1] = 2'd2;
      @(posedge clk); #1;
      htrans[1] = 2'd0; hwdata[1] = 32'h22222222;
      @(posedge clk); #2;
      chk("u1_pre_rst_hready", 32'(hready[1]), 32'd0);
      reset_n = 1'b0;
      #1;
      chk("u1_async_rst_hready", 32'(hready[1]), 32'd1);
      chk("u1_async_rst_hresp", 32'(hresp[1]), 32'd0);
      repeat (2) @(posedge clk);
      #2; reset_n = 1'b1;
      @(posedge clk); #1;
      hwdata[1] = 32'h0;
      add(0, 3'd2, 2'd2, BASE1 + 32'h40, 32'h0);
      run_seq(1);

      // BUSY, IDLE and deselected cycles: zero-wait OKAY, no RAM access
      hsel[0] = 1'b1; haddr[0] = 32'h10; hwrite[0] = 1'b1; hsize[0] = 3'd2;
      hwdata[0] = 32'hFFFFFFFF;
      for (int p = 0; p < 3; p++) begin
         htrans[0] = (p == 0) ? 2'd1 : ((p == 1) ? 2'd0 : 2'd2);
         hsel[0]   = (p != 2);
         @(negedge clk);
         chk($sformatf("u0_noxfer%0d_hready", p), 32'(hready[0]), 32'd1);
         chk($sformatf("u0_noxfer%0d_hresp", p), 32'(hresp[0]), 32'd0);
         @(posedge clk); #1;
      end
      hsel[0] = 1'b1; htrans[0] = 2'd0;
      @(posedge clk); #1;
      hwdata[0] = 32'h0;
      add(0, 3'd2, 2'd2, 32'h10, 32'h0);
      run_seq(0);

      repeat (2) @(posedge clk);
      #1;
      chk("u0_sb_left", 32'(sb0.size()), 32'd0);
      chk("u1_sb_left", 32'(sb1.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
